// File: rtl/z80_bus_responder_pkg.sv
// Shared types for the Z80 bus responder and its decoder.
// The strobe decoder is also meant to be reused by a bus tracer.
package z80_bus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  typedef enum logic [1:0] {ACC_MEM, ACC_IO, ACC_INTA} acc_t;

  localparam int WCNT_W = 3;

  // Minimum wait-state count for an access kind.
  function automatic logic [WCNT_W-1:0] wait_load(acc_t kind, int mem_wait, int io_wait);
    return (kind == ACC_IO) ? WCNT_W'(io_wait) : WCNT_W'(mem_wait);
  endfunction

endpackage

// File: rtl/z80_bus_responder_if.sv
// Z80 pin bundle plus backend handshake. The slave modport is the responder.
// The master modport is the CPU and backend side that drives it.
interface z80_bus_responder_if;
  logic        M1_n;
  logic        MREQ_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        WR_n;
  logic        RFSH_n;
  logic [15:0] A;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        DO_EN_n;
  logic        WAIT_n;
  logic        be_req;
  logic        be_we;
  logic        be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [7:0]  be_rdata;
  logic        be_ack;
  logic        err;

  modport slave (
    input  M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, A, DI, be_rdata, be_ack,
    output DO, DO_EN_n, WAIT_n, be_req, be_we, be_io, be_addr, be_wdata, err
  );

  modport master (
    output M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, A, DI, be_rdata, be_ack,
    input  DO, DO_EN_n, WAIT_n, be_req, be_we, be_io, be_addr, be_wdata, err
  );
endinterface

// File: rtl/z80_bus_responder_decode.sv
// Combinational Z80 strobe decoder: classifies the current bus cycle.
// Refresh cycles never hit. INTACK takes priority over IO, and IO over memory.
module z80_bus_decode
  import z80_bus_pkg::*;
(
  input  logic M1_n,
  input  logic MREQ_n,
  input  logic IORQ_n,
  input  logic RD_n,
  input  logic WR_n,
  input  logic RFSH_n,
  output logic hit,
  output acc_t kind
);

  logic strobe;
  assign strobe = ~RD_n | ~WR_n;

  always_comb begin
    hit  = 1'b0;
    kind = ACC_MEM;
    if (!IORQ_n && !M1_n) begin
      hit  = 1'b1;
      kind = ACC_INTA;
    end else if (!IORQ_n && strobe) begin
      hit  = 1'b1;
      kind = ACC_IO;
    end else if (!MREQ_n && RFSH_n && strobe) begin
      hit  = 1'b1;
      kind = ACC_MEM;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 target-side responder: turns CPU strobes into backend req/ack transfers.
// It also drives WAIT_n, the read data and the IM2 vector back to the CPU.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int          MEM_WAIT   = 0,
  parameter int          IO_WAIT    = 1,
  parameter int          TIMEOUT    = 64,
  parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
  input logic               CLK_n,
  input logic               RESET_n,
  z80_bus_responder_if.slave bus
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_d;
  logic [WCNT_W-1:0]   wcnt, wcnt_d;
  logic [TCNT_W-1:0]   tcnt, tcnt_d;
  logic                acked, acked_d;
  logic [7:0]          do_r, do_d;
  logic                do_en_n, do_en_n_d;
  logic                wait_n, wait_n_d;
  logic                be_req, be_req_d;
  logic                be_we, be_we_d;
  logic                be_io, be_io_d;
  logic [15:0]         be_addr, be_addr_d;
  logic [7:0]          be_wdata, be_wdata_d;
  logic                err, err_d;

  logic hit;
  acc_t kind;
  logic bus_free;
  logic ack_seen;

  z80_bus_decode u_decode (
    .M1_n   (bus.M1_n),
    .MREQ_n (bus.MREQ_n),
    .IORQ_n (bus.IORQ_n),
    .RD_n   (bus.RD_n),
    .WR_n   (bus.WR_n),
    .RFSH_n (bus.RFSH_n),
    .hit    (hit),
    .kind   (kind)
  );

  assign bus_free = bus.MREQ_n & bus.IORQ_n & bus.RD_n & bus.WR_n;
  assign ack_seen = acked | bus.be_ack;

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      tcnt     <= '0;
      acked    <= 1'b0;
      do_r     <= 8'h00;
      do_en_n  <= 1'b1;
      wait_n   <= 1'b1;
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_addr  <= 16'h0000;
      be_wdata <= 8'h00;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      wcnt     <= wcnt_d;
      tcnt     <= tcnt_d;
      acked    <= acked_d;
      do_r     <= do_d;
      do_en_n  <= do_en_n_d;
      wait_n   <= wait_n_d;
      be_req   <= be_req_d;
      be_we    <= be_we_d;
      be_io    <= be_io_d;
      be_addr  <= be_addr_d;
      be_wdata <= be_wdata_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    wcnt_d     = wcnt;
    tcnt_d     = tcnt;
    acked_d    = acked;
    do_d       = do_r;
    do_en_n_d  = do_en_n;
    wait_n_d   = wait_n;
    be_req_d   = be_req;
    be_we_d    = be_we;
    be_io_d    = be_io;
    be_addr_d  = be_addr;
    be_wdata_d = be_wdata;
    err_d      = 1'b0;

    unique case (state)
      IDLE: begin
        if (hit) begin
          if (kind == ACC_INTA) begin
            do_d      = INT_VECTOR;
            do_en_n_d = 1'b0;
            wait_n_d  = 1'b1;
            state_d   = HOLD;
          end else begin
            be_req_d   = 1'b1;
            be_we_d    = ~bus.WR_n;
            be_io_d    = (kind == ACC_IO);
            be_addr_d  = bus.A;
            be_wdata_d = bus.DI;
            wait_n_d   = 1'b0;
            wcnt_d     = wait_load(kind, MEM_WAIT, IO_WAIT);
            tcnt_d     = TCNT_W'(TIMEOUT);
            acked_d    = 1'b0;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        if (wcnt != '0) wcnt_d = wcnt - WCNT_W'(1);
        if (bus.be_ack) begin
          be_req_d = 1'b0;
          acked_d  = 1'b1;
          if (!be_we) do_d = bus.be_rdata;
        end
        // Order matters: CPU abort, then normal completion, then timeout.
        // A same-edge ack therefore beats the timeout.
        if (bus_free) begin
          wait_n_d = 1'b1;
          state_d  = ack_seen ? IDLE : DRAIN;
        end else if (ack_seen && wcnt == '0) begin
          wait_n_d = 1'b1;
          if (!be_we) do_en_n_d = 1'b0;
          state_d  = HOLD;
        end else if (!ack_seen && tcnt == TCNT_W'(1)) begin
          err_d    = 1'b1;
          do_d     = 8'hFF;
          wait_n_d = 1'b1;
          if (!be_we) do_en_n_d = 1'b0;
          state_d  = DRAIN;
        end else if (tcnt != '0) begin
          tcnt_d = tcnt - TCNT_W'(1);
        end
      end

      HOLD: begin
        if (bus_free) begin
          do_en_n_d = 1'b1;
          state_d   = IDLE;
        end
      end

      DRAIN: begin
        if (bus_free) do_en_n_d = 1'b1;
        if (bus.be_ack) begin
          be_req_d = 1'b0;
          state_d  = bus_free ? IDLE : HOLD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.DO       = do_r;
  assign bus.DO_EN_n  = do_en_n;
  assign bus.WAIT_n   = wait_n;
  assign bus.be_req   = be_req;
  assign bus.be_we    = be_we;
  assign bus.be_io    = be_io;
  assign bus.be_addr  = be_addr;
  assign bus.be_wdata = be_wdata;
  assign bus.err      = err;

endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Target-side counterpart of the Z80 pin interface: the memory/IO responder that a Z80 (or T80) master talks to.
- Decodes MREQ_n/IORQ_n/RD_n/WR_n/M1_n/RFSH_n from the CPU and forwards accesses to a backend over a req/ack handshake.
- Drives read data and WAIT_n back to the CPU, and supplies the IM2 vector on interrupt acknowledge.
- Replaces the real board's memory in closed-loop tests of the T80 core.

Parameters:
- MEM_WAIT, 0, minimum wait states inserted on memory accesses (0-7).
- IO_WAIT, 1, minimum wait states inserted on IO accesses (0-7).
- TIMEOUT, 64, CLK_n cycles to wait for backend ack before forcing completion.
- INT_VECTOR, 8'hFF, byte driven during interrupt acknowledge.

Ports:
- CLK_n  input  1  CPU clock; the block's single clock, rising edge.
- RESET_n  input  1  asynchronous, active-low reset.
- M1_n  input  1  CPU opcode-fetch strobe.
- MREQ_n  input  1  CPU memory request.
- IORQ_n  input  1  CPU IO request.
- RD_n  input  1  CPU read strobe.
- WR_n  input  1  CPU write strobe.
- RFSH_n  input  1  CPU refresh strobe.
- A  input  16  CPU address.
- DI  input  8  CPU write data.
- DO  output  8  read data to CPU.
- DO_EN_n  output  1  low while DO must be driven onto D.
- WAIT_n  output  1  wait request to CPU.
- be_req  output  1  backend request, level.
- be_we  output  1  backend write.
- be_io  output  1  backend IO space select.
- be_addr  output  16  backend address.
- be_wdata  output  8  backend write data.
- be_rdata  input  8  backend read data, valid with be_ack.
- be_ack  input  1  one-cycle backend completion.
- err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset values: DO=8'h00, DO_EN_n=1, WAIT_n=1, be_req=0, be_we=0, be_io=0, be_addr=0, be_wdata=0, err=0. State=IDLE.
- Clocking: all CPU inputs are sampled on rising CLK_n. All outputs are registered.
- Access decode (IDLE only), in priority order:
  - INTACK: IORQ_n=0 and M1_n=0.
  - IO: IORQ_n=0, M1_n=1, (RD_n=0 or WR_n=0).
  - MEM: MREQ_n=0, RFSH_n=1, (RD_n=0 or WR_n=0).
  - Refresh cycles (MREQ_n=0 and RFSH_n=0) are ignored.
- States:
  - IDLE -> REQ on MEM/IO decode. Latch A to be_addr and DI to be_wdata; set be_we=~WR_n, be_io per decode; be_req=1; WAIT_n=0; load the wait counter with MEM_WAIT or IO_WAIT; load the timeout counter.
  - IDLE -> HOLD on INTACK: DO=INT_VECTOR, DO_EN_n=0, WAIT_n=1, no backend access.
  - REQ: the wait counter decrements to 0 and saturates there. On be_ack: be_req=0 and capture be_rdata into DO (reads). Exit to HOLD once ack has been seen and the counter is 0; WAIT_n=1 on the HOLD entry edge. For reads, DO_EN_n=0 on the same edge.
  - REQ timeout: counter expiry without ack -> err pulse, DO=8'hFF, go to DRAIN. be_req stays high until ack; WAIT_n releases and the read completes with 8'hFF.
  - HOLD: DO/DO_EN_n are held until all of MREQ_n, IORQ_n, RD_n, WR_n are sampled high. Then DO_EN_n=1 and go to IDLE.
  - DRAIN: waits for be_ack, discards the data, then goes to IDLE. If the CPU strobes are still low on ack, go to HOLD instead.
- Abort: strobes released while in REQ -> WAIT_n=1 and go to DRAIN. A handshake already issued is never dropped before ack.
- be_ack in the same cycle as the timeout expiry: the ack wins and no err is raised.
- be_ack outside REQ/DRAIN is ignored.
- A new access is never accepted outside IDLE.
- Zero wait states with a same-cycle ack still holds WAIT_n low for exactly one sampled cycle (registered path).
- RESET_n low mid-transaction: immediate return to reset values. be_req drops and the backend must tolerate this.

Decomposition:
- Package z80_bus_pkg holds:
  - state enum {IDLE, REQ, HOLD, DRAIN};
  - access-kind enum {ACC_MEM, ACC_IO, ACC_INTA};
  - the 3-bit wait-counter width.
- Sub-module z80_bus_decode: combinational strobe-to-access-kind decoder, reusable by the tracer.

Test Plan:
- Memory read A=16'h1234, MEM_WAIT=0, backend acks after 1 cycle with 8'hA5 -> be_req for 1 cycle, DO=8'hA5, DO_EN_n low until RD_n rises, WAIT_n low for 1 sampled cycle.
- IO write A=16'h00FE, DI=8'h3C, IO_WAIT=1 -> be_io=1, be_we=1, be_wdata=8'h3C, WAIT_n low for at least 2 cycles, DO_EN_n never low.
- Interrupt ack (M1_n=0, IORQ_n=0), INT_VECTOR=8'h38 -> DO=8'h38, DO_EN_n=0, be_req never asserted.
- Refresh (MREQ_n=0, RFSH_n=0) -> no be_req, WAIT_n stays 1.
- Backend never acks, TIMEOUT=64 -> err pulse at cycle 64, DO=8'hFF, WAIT_n=1, be_req held until a late ack, then IDLE.
- RESET_n pulsed low while in REQ -> all outputs at reset values immediately; the next read completes normally.
